// File: rtl/util_fifo_axis_pack_if.sv
// Wide AXI-Stream bus carrying packed beats out of util_fifo_axis_pack.
// Carries tkeep only when PACK_FLUSH_EN is defined.
interface util_fifo_axis_pack_if #(
  parameter int unsigned DATA_W = 128
`ifdef PACK_FLUSH_EN
  ,
  parameter int unsigned KEEP_W = 4
`endif
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
`ifdef PACK_FLUSH_EN
  logic [KEEP_W-1:0] tkeep;

  modport master (output tdata, output tvalid, output tlast, output tkeep, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tkeep, output tready);
`else
  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
`endif
endinterface

// File: rtl/util_fifo_axis_pack.sv
// Pops narrow FWFT FIFO words, packs RATIO of them per wide AXI-Stream beat, frames PKT_BEATS
// beats per packet. Define PACK_FLUSH_EN to add flush of partial beats with a tkeep mask.
module util_fifo_axis_pack #(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned RATIO     = 4,
  parameter int unsigned PKT_BEATS = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IN_WIDTH-1:0]   i_fifo_dout,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_rden,
  util_fifo_axis_pack_if.master m_axis,
  output logic                  o_busy
`ifdef PACK_FLUSH_EN
  ,
  input  logic                  i_flush
`endif
);

  localparam int unsigned OUT_W  = IN_WIDTH * RATIO;
  localparam int unsigned ACC_W  = IN_WIDTH * (RATIO - 1);
  localparam int unsigned WIDX_W = $clog2(RATIO);
  localparam int unsigned PKT_W  = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
  localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(RATIO - 1);
  localparam logic [PKT_W-1:0]  PKT_LAST  = PKT_W'(PKT_BEATS - 1);

  // The last word of a beat goes straight into r_tdata, so acc only holds RATIO-1 words.
  logic [ACC_W-1:0]  r_acc,     w_acc_nxt;
  logic [WIDX_W-1:0] r_widx,    w_widx_nxt;
  logic [OUT_W-1:0]  r_tdata,   w_tdata_nxt;
  logic              r_tvalid,  w_tvalid_nxt;
  logic [PKT_W-1:0]  r_pkt_cnt, w_pkt_cnt_nxt;

  logic w_out_free;
  logic w_hs;
  logic w_widx_last;
  logic w_flush_hold;
  logic w_pkt_wrap;

`ifdef PACK_FLUSH_EN
  logic [RATIO-1:0] r_tkeep,      w_tkeep_nxt;
  logic             r_flush_pend, w_flush_pend_nxt;
  logic             r_flush_beat, w_flush_beat_nxt;
  logic [OUT_W-1:0] w_flush_data;
  logic [RATIO-1:0] w_flush_keep;

  assign w_flush_hold = r_flush_pend;
  assign w_pkt_wrap   = (r_pkt_cnt == PKT_LAST) | r_flush_beat;
  assign m_axis.tlast = r_tvalid & ((r_pkt_cnt == PKT_LAST) | r_flush_beat);
  assign m_axis.tkeep = r_tkeep;
`else
  assign w_flush_hold = 1'b0;
  assign w_pkt_wrap   = (r_pkt_cnt == PKT_LAST);
  assign m_axis.tlast = r_tvalid & (r_pkt_cnt == PKT_LAST);
`endif

  assign w_out_free   = ~r_tvalid | m_axis.tready;
  assign w_hs         = r_tvalid & m_axis.tready;
  assign w_widx_last  = (r_widx == WIDX_LAST);
  // The word completing a beat may only be popped when the output register can take it.
  assign o_fifo_rden  = rst_n & ~i_fifo_empty & (~w_widx_last | w_out_free) & ~w_flush_hold;

  assign m_axis.tdata  = r_tdata;
  assign m_axis.tvalid = r_tvalid;
  assign o_busy        = (r_widx != '0) | r_tvalid;

  always_comb begin
    w_acc_nxt     = r_acc;
    w_widx_nxt    = r_widx;
    w_tdata_nxt   = r_tdata;
    w_tvalid_nxt  = r_tvalid;
    w_pkt_cnt_nxt = r_pkt_cnt;
`ifdef PACK_FLUSH_EN
    w_tkeep_nxt      = r_tkeep;
    w_flush_pend_nxt = r_flush_pend;
    w_flush_beat_nxt = r_flush_beat;
    w_flush_data     = '0;
    w_flush_keep     = '0;
    for (int unsigned k = 0; k < RATIO - 1; k++) begin
      if (WIDX_W'(k) < r_widx) begin
        w_flush_data[k*IN_WIDTH +: IN_WIDTH] = r_acc[k*IN_WIDTH +: IN_WIDTH];
        w_flush_keep[k]                      = 1'b1;
      end
    end
`endif

    if (w_hs) begin
      w_tvalid_nxt  = 1'b0;
      w_pkt_cnt_nxt = w_pkt_wrap ? '0 : r_pkt_cnt + PKT_W'(1);
    end

    if (o_fifo_rden) begin
      if (w_widx_last) begin
        w_widx_nxt   = '0;
        w_tdata_nxt  = {i_fifo_dout, r_acc};
        w_tvalid_nxt = 1'b1;
`ifdef PACK_FLUSH_EN
        w_tkeep_nxt      = '1;
        w_flush_beat_nxt = 1'b0;
`endif
      end else begin
        for (int unsigned k = 0; k < RATIO - 1; k++) begin
          if (r_widx == WIDX_W'(k)) w_acc_nxt[k*IN_WIDTH +: IN_WIDTH] = i_fifo_dout;
        end
        w_widx_nxt = r_widx + WIDX_W'(1);
      end
    end

`ifdef PACK_FLUSH_EN
    if (r_flush_pend && w_out_free) begin
      w_tdata_nxt      = w_flush_data;
      w_tkeep_nxt      = w_flush_keep;
      w_tvalid_nxt     = 1'b1;
      w_flush_beat_nxt = 1'b1;
      w_widx_nxt       = '0;
      w_flush_pend_nxt = 1'b0;
    end else if (i_flush && (w_widx_nxt != '0)) begin
      // Judged on the post-pop index so a flush racing a completed beat emits nothing empty.
      w_flush_pend_nxt = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_widx    <= '0;
      r_tdata   <= '0;
      r_tvalid  <= 1'b0;
      r_pkt_cnt <= '0;
`ifdef PACK_FLUSH_EN
      r_tkeep      <= '0;
      r_flush_pend <= 1'b0;
      r_flush_beat <= 1'b0;
`endif
    end else begin
      r_acc     <= w_acc_nxt;
      r_widx    <= w_widx_nxt;
      r_tdata   <= w_tdata_nxt;
      r_tvalid  <= w_tvalid_nxt;
      r_pkt_cnt <= w_pkt_cnt_nxt;
`ifdef PACK_FLUSH_EN
      r_tkeep      <= w_tkeep_nxt;
      r_flush_pend <= w_flush_pend_nxt;
      r_flush_beat <= w_flush_beat_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_util_fifo_axis_pack.sv
// Randomized bench for util_fifo_axis_pack: a queue-based FIFO and a word-list packing model
// predict every beat; AXIS hold rules are watched every cycle.
module tb_util_fifo_axis_pack;
  localparam int unsigned IN_WIDTH  = 32;
  localparam int unsigned RATIO     = 4;
  localparam int unsigned PKT_BEATS = 16;
  localparam int unsigned OUT_W     = IN_WIDTH * RATIO;

  typedef struct {
    logic [OUT_W-1:0] data;
    logic             last;
    logic [RATIO-1:0] keep;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [IN_WIDTH-1:0] fifo_dout;
  logic fifo_empty;
  logic fifo_rden;
  logic busy;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  util_fifo_axis_pack_if #(
    .DATA_W(OUT_W)
`ifdef PACK_FLUSH_EN
    ,
    .KEEP_W(RATIO)
`endif
  ) m_axis ();

  util_fifo_axis_pack #(
    .IN_WIDTH (IN_WIDTH),
    .RATIO    (RATIO),
    .PKT_BEATS(PKT_BEATS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_fifo_dout (fifo_dout),
    .i_fifo_empty(fifo_empty),
    .o_fifo_rden (fifo_rden),
    .m_axis      (m_axis.master),
    .o_busy      (busy)
`ifdef PACK_FLUSH_EN
    ,
    .i_flush     (flush)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [IN_WIDTH-1:0] fifo_q[$];
  logic [IN_WIDTH-1:0] pend[$];
  beat_t               exp_q[$];
  int unsigned         beat_idx = 0;

  logic [OUT_W-1:0] got_data[$];
  logic             got_last[$];
  int               hs_cycles[$];

  logic             stall_prev = 1'b0;
  logic [OUT_W-1:0] held_data;
  logic             held_last;

  // Reference: every RATIO consecutive words form one beat; tlast by beat position in packet.
  function automatic void model_emit(int unsigned n, bit force_last);
    beat_t b;
    b.data = '0;
    for (int unsigned k = 0; k < n; k++) b.data |= OUT_W'(pend[k]) << (k * IN_WIDTH);
    b.keep = RATIO'((1 << n) - 1);
    b.last = force_last || (beat_idx == PKT_BEATS - 1);
    beat_idx = force_last ? 0 : (beat_idx + 1) % PKT_BEATS;
    pend.delete();
    exp_q.push_back(b);
  endfunction

  function automatic void update_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_dout  = fifo_empty ? 32'hDEAD_BEEF : fifo_q[0];
  endfunction

  function automatic void push(logic [IN_WIDTH-1:0] w);
    fifo_q.push_back(w);
    pend.push_back(w);
    if (pend.size() == RATIO) model_emit(RATIO, 1'b0);
    update_fifo();
  endfunction

  task automatic cycle();
    logic  pop;
    beat_t b;
    @(negedge clk);
    pop = fifo_rden;
    if (stall_prev) begin
      checks++;
      if (m_axis.tvalid !== 1'b1 || m_axis.tdata !== held_data || m_axis.tlast !== held_last) begin
        errors++;
        $display("FAIL axis_hold: got tvalid=%b tdata=%h tlast=%b, want tvalid=1 tdata=%h tlast=%b",
                 m_axis.tvalid, m_axis.tdata, m_axis.tlast, held_data, held_last);
      end
    end
    stall_prev = rst_n & m_axis.tvalid & ~m_axis.tready;
    held_data  = m_axis.tdata;
    held_last  = m_axis.tlast;
    if (rst_n && m_axis.tvalid && m_axis.tready) begin
      hs_cycles.push_back(cyc);
      got_data.push_back(m_axis.tdata);
      got_last.push_back(m_axis.tlast);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got tdata=%h, want no beat", m_axis.tdata);
      end else begin
        b = exp_q.pop_front();
`ifdef PACK_FLUSH_EN
        if (m_axis.tkeep !== b.keep) begin
          errors++;
          $display("FAIL beat_keep: got %b, want %b", m_axis.tkeep, b.keep);
        end
`endif
        if (m_axis.tdata !== b.data || m_axis.tlast !== b.last) begin
          errors++;
          $display("FAIL beat: got tdata=%h tlast=%b, want tdata=%h tlast=%b",
                   m_axis.tdata, m_axis.tlast, b.data, b.last);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (pop) begin
      if (fifo_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_empty: got rden=1, want 0 while empty");
      end else begin
        void'(fifo_q.pop_front());
      end
    end
    update_fifo();
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < 2000) begin
      cycle();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || fifo_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d beats / %0d words left, want 0 / 0",
               exp_q.size(), fifo_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m_axis.tready = 1'b1;
    fifo_q.push_back(32'h55);
    update_fifo();
    repeat (3) cycle();
    checks++;
    if (m_axis.tvalid !== 1'b0 || m_axis.tdata !== '0 || m_axis.tlast !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got tvalid=%b tdata=%h tlast=%b busy=%b, want all 0",
               m_axis.tvalid, m_axis.tdata, m_axis.tlast, busy);
    end
    checks++;
    if (fifo_rden !== 1'b0) begin
      errors++;
      $display("FAIL reset_rden: got %b, want 0", fifo_rden);
    end
`ifdef PACK_FLUSH_EN
    checks++;
    if (m_axis.tkeep !== '0) begin
      errors++;
      $display("FAIL reset_tkeep: got %b, want 0", m_axis.tkeep);
    end
`endif
    checks++;
    if (fifo_q.size() != 1) begin
      errors++;
      $display("FAIL reset_fifo_untouched: got %0d words, want 1", fifo_q.size());
    end
    fifo_q.delete();
    update_fifo();
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_packet();
    m_axis.tready = 1'b1;
    hs_cycles.delete();
    got_last.delete();
    for (int i = 0; i < 16 * RATIO; i++) push($urandom());
    drain();
    checks++;
    if (hs_cycles.size() != 16 || hs_cycles[15] - hs_cycles[0] != 15 * RATIO) begin
      errors++;
      $display("FAIL packet_rate: got %0d beats over %0d cycles, want 16 over %0d",
               hs_cycles.size(), hs_cycles.size() ? hs_cycles[$] - hs_cycles[0] : 0, 15 * RATIO);
    end
    checks++;
    if (got_last.size() != 16 || got_last.sum() with (int'(item)) != 1 || got_last[15] !== 1'b1) begin
      errors++;
      $display("FAIL packet_tlast: got %0d tlast beats, want exactly one on beat 16",
               got_last.sum() with (int'(item)));
    end
  endtask

  task automatic test_basic();
    logic [OUT_W-1:0] want0 = 128'h00000004_00000003_00000002_00000001;
    logic [OUT_W-1:0] want1 = 128'h00000008_00000007_00000006_00000005;
    m_axis.tready = 1'b1;
    got_data.delete();
    got_last.delete();
    for (int i = 1; i <= 8; i++) push(IN_WIDTH'(i));
    drain();
    checks++;
    if (got_data.size() != 2 || got_data[0] !== want0 || got_data[1] !== want1) begin
      errors++;
      $display("FAIL basic_pack: got %0d beats first=%h, want 2 beats %h then %h",
               got_data.size(), got_data.size() ? got_data[0] : '0, want0, want1);
    end
    checks++;
    if (got_last.size() != 2 || got_last[0] !== 1'b0 || got_last[1] !== 1'b0) begin
      errors++;
      $display("FAIL basic_tlast: got tlast set on a beat, want none");
    end
  endtask

  task automatic test_backpressure();
    m_axis.tready = 1'b0;
    got_data.delete();
    for (int i = 0; i < 12; i++) push($urandom());
    repeat (20) cycle();
    checks++;
    if (m_axis.tvalid !== 1'b1 || m_axis.tdata !== exp_q[0].data) begin
      errors++;
      $display("FAIL bp_held: got tvalid=%b tdata=%h, want 1 %h",
               m_axis.tvalid, m_axis.tdata, exp_q[0].data);
    end
    // One beat in the output register plus RATIO-1 words accumulated; the rest wait in the FIFO.
    checks++;
    if (fifo_rden !== 1'b0 || fifo_q.size() != 12 - (2 * RATIO - 1)) begin
      errors++;
      $display("FAIL bp_stop: got rden=%b fifo=%0d, want rden=0 fifo=%0d",
               fifo_rden, fifo_q.size(), 12 - (2 * RATIO - 1));
    end
    m_axis.tready = 1'b1;
    drain();
    checks++;
    if (got_data.size() != 3) begin
      errors++;
      $display("FAIL bp_count: got %0d beats, want 3", got_data.size());
    end
  endtask

  task automatic test_stall();
    logic [OUT_W-1:0] want = 128'h0000000D_0000000C_0000000B_0000000A;
    m_axis.tready = 1'b1;
    got_data.delete();
    push(32'hA);
    push(32'hB);
    repeat (20) begin
      cycle();
      checks++;
      if (busy !== 1'b1 || m_axis.tvalid !== 1'b0) begin
        errors++;
        $display("FAIL stall_state: got busy=%b tvalid=%b, want busy=1 tvalid=0", busy, m_axis.tvalid);
      end
    end
    push(32'hC);
    push(32'hD);
    drain();
    checks++;
    if (got_data.size() != 1 || got_data[0] !== want) begin
      errors++;
      $display("FAIL stall_beat: got %0d beats first=%h, want 1 beat %h",
               got_data.size(), got_data.size() ? got_data[0] : '0, want);
    end
  endtask

  task automatic test_reset_mid();
    m_axis.tready = 1'b0;
    for (int i = 0; i < RATIO + 2; i++) push($urandom());
    repeat (10) cycle();
    checks++;
    if (m_axis.tvalid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_pending: got tvalid=%b busy=%b, want 1 1", m_axis.tvalid, busy);
    end
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    exp_q.delete();
    pend.delete();
    beat_idx = 0;
    checks++;
    if (m_axis.tvalid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got tvalid=%b busy=%b, want 0 0", m_axis.tvalid, busy);
    end
    m_axis.tready = 1'b1;
    for (int i = 0; i < 16 * RATIO; i++) push($urandom());
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      m_axis.tready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) != 0) push($urandom());
      cycle();
    end
    while (pend.size() != 0) push($urandom());
    m_axis.tready = 1'b1;
    drain();
  endtask

`ifdef PACK_FLUSH_EN
  task automatic test_flush();
    int unsigned n0;
    m_axis.tready = 1'b1;
    got_data.delete();
    got_last.delete();
    push(32'h11);
    push(32'h22);
    repeat (4) cycle();
    model_emit(pend.size(), 1'b1);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    drain();
    checks++;
    if (got_data.size() != 1 || got_data[0] !== 128'h22_00000011 || got_last[0] !== 1'b1) begin
      errors++;
      $display("FAIL flush_beat: got %0d beats first=%h, want 1 beat %h with tlast",
               got_data.size(), got_data.size() ? got_data[0] : '0, 128'h22_00000011);
    end
    n0 = got_data.size();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    repeat (10) cycle();
    checks++;
    if (got_data.size() != n0 || m_axis.tvalid !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: got %0d beats tvalid=%b, want %0d beats tvalid=0",
               got_data.size(), m_axis.tvalid, n0);
    end
    for (int i = 0; i < 16 * RATIO; i++) push($urandom());
    drain();
  endtask
`endif

  initial begin
    m_axis.tready = 1'b0;
    update_fifo();
    test_reset();
    test_packet();
    test_basic();
    test_backpressure();
    test_stall();
    test_reset_mid();
    test_random();
`ifdef PACK_FLUSH_EN
    test_flush();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog");
  end
endmodule
